router_pkt_tx: RTL and testbench
================================

Name: router_pkt_tx

Overview:
Packet transmitter that drives the router input port (packet_valid, datain) and honours the router busy back-pressure.
- Host loads payload bytes into an internal buffer, then issues start with a destination address.
- Block emits header {len[5:0], addr[1:0]}, the payload, then the parity byte (XOR of header and all payload bytes).
- Used as the upstream source on chip, and as the stimulus generator for router-level benches.

Parameters:
MAX_LEN, 63, payload buffer depth in bytes; legal range 1..63, since the header length field is 6 bits.
GAP_CYCLES, 2, idle cycles inserted after the parity byte before the next start is accepted.

Ports:
clk  input  1  clock, rising edge.
resetn  input  1  asynchronous active-low reset.
wr_en  input  1  write one payload byte into the buffer.
wr_data  input  8  payload byte.
start  input  1  launch packet; sampled only in IDLE.
dest_addr  input  2  destination port 0..2; 3 is illegal.
inject_err  input  1  corrupt parity of this packet; used only when the macro is defined.
busy  input  1  router back-pressure.
packet_valid  output  1  to router.
datain  output  8  byte to router.
buf_cnt  output  6  bytes currently buffered.
buf_full  output  1  buf_cnt == MAX_LEN.
tx_active  output  1  high from HEADER through GAP.
done  output  1  one-cycle pulse at the end of GAP.
cmd_err  output  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; packet_valid=0, datain=0, buf_cnt=0, tx_active=0, done=0, cmd_err=0; parity accumulator and read pointer cleared.
- Buffer writes:
  - Accepted only when tx_active=0 and buf_full=0; buf_cnt increments the next cycle.
  - Writes while tx_active=1 or buf_full=1 are dropped silently.
- IDLE:
  - start=1 with buf_cnt=0 or dest_addr=3 gives cmd_err=1 for one cycle; state stays IDLE and the buffer is unchanged.
  - start=1 with a legal command latches addr and len=buf_cnt, goes to HEADER next cycle, tx_active=1.
  - start and wr_en in the same cycle: the write is accepted and counted in len.
- HEADER: packet_valid=1, datain={len,addr}, parity=header.
- Advance rule, applying to HEADER, PAYLOAD and PARITY: a byte is consumed on a rising edge where busy=0. While busy=1, packet_valid and datain hold unchanged.
- HEADER to PAYLOAD on consume.
- PAYLOAD: packet_valid=1, datain=buf[rd_ptr].
  - On consume: parity ^= byte and rd_ptr++.
  - After byte len-1 is consumed, go to PARITY.
- PARITY: packet_valid=0, datain=parity; on consume go to GAP.
- GAP:
  - packet_valid=0, datain=0.
  - Counts GAP_CYCLES cycles regardless of busy.
  - On the last GAP cycle done=1; buf_cnt and rd_ptr clear to 0; tx_active=0 next cycle.
  - Next state is IDLE.
- Latency: with busy=0 throughout, header appears on the cycle after start is sampled, and the packet occupies len+2 cycles on datain.
- start outside IDLE is ignored, with no cmd_err.
- Reset mid-packet aborts immediately: packet_valid drops asynchronously and the buffer contents are discarded.
- Buffer storage is not reset; only pointers and counters are.

Optional Feature:
PKT_TX_BAD_PARITY_EN
- Defined: inject_err is sampled with an accepted start; if it was 1, the transmitted parity byte is the true parity XOR 8'hFF.
- Undefined: inject_err is ignored and parity is always correct.

Test Plan:
1. Write 3 bytes 8'h11, 8'h22, 8'h33; start with dest_addr=1, busy=0.
   -> datain sequence 8'h0D, 11, 22, 33 with packet_valid=1, then parity 8'h0D with packet_valid=0.
   -> done pulses 3 cycles (GAP_CYCLES+1) after the parity byte; buf_cnt=0.
2. Same packet with busy=1 for 2 cycles during HEADER and 1 cycle during payload byte 2.
   -> each byte is held stable while busy; the total packet takes 3 extra cycles; byte order and parity are unchanged.
3. start with buf_cnt=0, or with dest_addr=3.
   -> cmd_err pulses once, state stays IDLE, packet_valid stays 0.
4. Write 64 bytes with MAX_LEN=63.
   -> buf_full=1 and buf_cnt=63; the 64th byte is dropped; the header is 8'hFC|addr.
5. Assert resetn low during payload byte 5 of a 10-byte packet.
   -> packet_valid=0 and buf_cnt=0 immediately; a subsequent 1-byte packet is sent correctly.
6. Macro defined, inject_err=1, packet from test 1.
   -> parity byte is 8'hF2; done still pulses.

Source files
------------

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet source for the router input port (header, payload, parity) with busy back-pressure; optional parity corruption under PKT_TX_BAD_PARITY_EN
module router_pkt_tx #(
    parameter int MAX_LEN    = 63,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic       inject_err,
    input  logic       busy,
    output logic       packet_valid,
    output logic [7:0] datain,
    output logic [5:0] buf_cnt,
    output logic       buf_full,
    output logic       tx_active,
    output logic       done,
    output logic       cmd_err
);
    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, GAP} state_t;
    state_t state, state_nx;
    logic [7:0] mem [MAX_LEN];
    logic [5:0] len, rd_ptr, len_nx;
    logic [1:0] addr;
    logic [7:0] parity, gap_cnt, par_mask;
    logic wr_ok, start_ok, start_bad, gap_last;

    assign tx_active = state != IDLE;
    assign buf_full  = buf_cnt == 6'(MAX_LEN);
    assign wr_ok     = wr_en && !tx_active && !buf_full;
    assign start_ok  = state == IDLE && start && buf_cnt != 6'd0 && dest_addr != 2'd3;
    assign start_bad = state == IDLE && start && (buf_cnt == 6'd0 || dest_addr == 2'd3);
    assign len_nx    = buf_cnt + 6'(wr_ok);
    assign gap_last  = state == GAP && gap_cnt == 8'(GAP_CYCLES - 1);

`ifdef PKT_TX_BAD_PARITY_EN
    // capture the corruption request together with the accepted command
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) par_mask <= 8'h00;
        else if (start_ok) par_mask <= {8{inject_err}};
`else
    logic unused_inject;
    assign unused_inject = inject_err;
    assign par_mask = 8'h00;
`endif

    // payload storage is deliberately left unreset; only the pointers are cleared
    always_ff @(posedge clk)
        if (wr_ok) mem[buf_cnt] <= wr_data;

    // state register
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= IDLE;
        else state <= state_nx;

    // next state and port outputs; a byte advances only on an edge with busy low
    always_comb begin
        state_nx = state;
        packet_valid = 1'b0;
        datain = 8'h00;
        unique case (state)
            IDLE: if (start_ok) state_nx = HEADER;
            HEADER: begin
                packet_valid = 1'b1;
                datain = {len, addr};
                if (!busy) state_nx = PAYLOAD;
            end
            PAYLOAD: begin
                packet_valid = 1'b1;
                datain = mem[rd_ptr];
                if (!busy && rd_ptr == len - 6'd1) state_nx = PARITY;
            end
            PARITY: begin
                datain = parity ^ par_mask;
                if (!busy) state_nx = GAP;
            end
            GAP: if (gap_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // buffer count, command latch, parity accumulation, gap timing and status pulses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_cnt <= 6'd0;
            len     <= 6'd0;
            addr    <= 2'd0;
            rd_ptr  <= 6'd0;
            parity  <= 8'h00;
            gap_cnt <= 8'h00;
            done    <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            done    <= gap_last;
            cmd_err <= start_bad;
            gap_cnt <= state == GAP ? gap_cnt + 8'd1 : 8'h00;
            if (gap_last) buf_cnt <= 6'd0;
            else if (wr_ok) buf_cnt <= buf_cnt + 6'd1;
            if (start_ok) begin
                len    <= len_nx;
                addr   <= dest_addr;
                parity <= {len_nx, dest_addr};
                rd_ptr <= 6'd0;
            end
            if (state == PAYLOAD && !busy) begin
                parity <= parity ^ mem[rd_ptr];
                rd_ptr <= rd_ptr + 6'd1;
            end
            if (gap_last) rd_ptr <= 6'd0;
        end
    end
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: directed scoreboard bench for router_pkt_tx
module tb_router_pkt_tx;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic start = 1'b0;
    logic [1:0] dest_addr = 2'd0;
    logic inject_err = 1'b0;
    logic busy = 1'b0;
    logic packet_valid, buf_full, tx_active, done, cmd_err;
    logic [7:0] datain;
    logic [5:0] buf_cnt;

    int nvec = 0;
    int nerr = 0;
    logic [8:0] sb [$];
    logic [7:0] mb [$];

    router_pkt_tx dut (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data),
        .start(start), .dest_addr(dest_addr), .inject_err(inject_err), .busy(busy),
        .packet_valid(packet_valid), .datain(datain), .buf_cnt(buf_cnt),
        .buf_full(buf_full), .tx_active(tx_active), .done(done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    // stream monitor: pops the scoreboard on each consumed byte, checks hold while busy
    logic [8:0] prev = 9'h0;
    logic prev_busy = 1'b0;
    logic in_pkt = 1'b0;
    always @(negedge clk) begin
        logic [8:0] obs, e;
        if (!resetn) begin
            in_pkt = 1'b0;
            prev_busy = 1'b0;
        end else begin
            obs = {packet_valid, datain};
            if (in_pkt && prev_busy) chk("hold", 32'(obs), 32'(prev));
            if (!in_pkt && packet_valid) in_pkt = 1'b1;
            if (in_pkt && !busy) begin
                e = sb.size() != 0 ? sb.pop_front() : 9'bx;
                chk("byte", 32'(obs), 32'(e));
                if (e[8] !== 1'b1) in_pkt = 1'b0;
            end
            prev = obs;
            prev_busy = in_pkt && busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        if (mb.size() < 63) mb.push_back(b);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic launch(input logic [1:0] a, input logic inj, input logic extra, input logic [7:0] xb);
        logic [7:0] hdr, par;
        logic [5:0] l;
        if (extra) begin
            wr_en = 1'b1;
            wr_data = xb;
            if (mb.size() < 63) mb.push_back(xb);
        end
        l = 6'(mb.size());
        hdr = {l, a};
        par = hdr;
        sb.push_back({1'b1, hdr});
        foreach (mb[i]) begin
            sb.push_back({1'b1, mb[i]});
            par ^= mb[i];
        end
`ifdef PKT_TX_BAD_PARITY_EN
        if (inj) par ^= 8'hFF;
`endif
        sb.push_back({1'b0, par});
        start = 1'b1;
        dest_addr = a;
        inject_err = inj;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        inject_err = 1'b0;
    endtask

    task automatic finish_pkt(input logic [31:0] bmask, input int exp_n);
        int k;
        for (k = 0; k < 300; k++) begin
            busy = k < 32 ? bmask[k] : 1'b0;
            tick();
            if (done) break;
        end
        busy = 1'b0;
        chk("done_latency", 32'(k + 1), 32'(exp_n));
        chk("buf_cnt_after", 32'(buf_cnt), 32'd0);
        chk("tx_active_after", 32'(tx_active), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        mb.delete();
        tick();
        chk("done_pulse_end", 32'(done), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_pv", 32'(packet_valid), 32'd0);
        chk("rst_datain", 32'(datain), 32'd0);
        chk("rst_buf_cnt", 32'(buf_cnt), 32'd0);
        chk("rst_tx_active", 32'(tx_active), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cmd_err", 32'(cmd_err), 32'd0);
        resetn = 1'b1;
        tick();

        // basic 3-byte packet, no back-pressure
        wr(8'h11); wr(8'h22); wr(8'h33);
        chk("t1_buf_cnt", 32'(buf_cnt), 32'd3);
        launch(2'd1, 1'b0, 1'b0, 8'h00);
        chk("t1_hdr_pv", 32'(packet_valid), 32'd1);
        chk("t1_hdr", 32'(datain), 32'h0D);
        chk("t1_tx_active", 32'(tx_active), 32'd1);
        finish_pkt(32'h0, 7);

        // same packet, busy for 2 header cycles and 1 cycle on payload byte 2
        wr(8'h11); wr(8'h22); wr(8'h33);
        launch(2'd1, 1'b0, 1'b0, 8'h00);
        finish_pkt(32'h13, 10);

        // rejected commands: empty buffer, then illegal destination
        dest_addr = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_err_empty", 32'(cmd_err), 32'd1);
        chk("t3_pv_empty", 32'(packet_valid), 32'd0);
        chk("t3_txa_empty", 32'(tx_active), 32'd0);
        tick();
        chk("t3_err_pulse", 32'(cmd_err), 32'd0);
        wr(8'hAA);
        dest_addr = 2'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_err_addr3", 32'(cmd_err), 32'd1);
        chk("t3_buf_kept", 32'(buf_cnt), 32'd1);
        chk("t3_txa_addr3", 32'(tx_active), 32'd0);
        launch(2'd2, 1'b0, 1'b0, 8'h00);
        chk("t3_hdr", 32'(datain), 32'h06);
        finish_pkt(32'h0, 5);

        // overfill: 64 writes, last one dropped
        for (int i = 0; i < 64; i++) wr(8'(i * 7 + 5));
        chk("t4_buf_cnt", 32'(buf_cnt), 32'd63);
        chk("t4_buf_full", 32'(buf_full), 32'd1);
        launch(2'd2, 1'b0, 1'b0, 8'h00);
        chk("t4_hdr", 32'(datain), 32'hFE);
        finish_pkt(32'h0, 67);

        // reset during payload byte 5 of a 10-byte packet
        for (int i = 0; i < 10; i++) wr(8'(i * 3 + 1));
        launch(2'd0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) tick();
        chk("t5_pv_before", 32'(packet_valid), 32'd1);
        resetn = 1'b0;
        #1;
        chk("t5_pv_abort", 32'(packet_valid), 32'd0);
        chk("t5_buf_abort", 32'(buf_cnt), 32'd0);
        chk("t5_txa_abort", 32'(tx_active), 32'd0);
        sb.delete();
        mb.delete();
        tick();
        resetn = 1'b1;
        tick();
        wr(8'h5A);
        launch(2'd1, 1'b0, 1'b0, 8'h00);
        chk("t5_hdr", 32'(datain), 32'h05);
        finish_pkt(32'h0, 5);

        // write in the start cycle counts in len; inject_err request on the same start
        wr(8'h11); wr(8'h22);
        launch(2'd1, 1'b1, 1'b1, 8'h33);
        chk("t6_hdr", 32'(datain), 32'h0D);
        finish_pkt(32'h0, 7);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
